// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate sequencer and its end-around register.
package rotate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic ROT_RIGHT = 1'b0;
  localparam logic ROT_LEFT  = 1'b1;

endpackage

// File: rtl/rotate_reg.sv
// WIDTH-bit end-around shift register: parallel load has priority over a
// single-position rotate; holds otherwise.
module rotate_reg
  import rotate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] rot_s;

  // One-position rotation of the current contents in the requested direction
  always_comb begin
    rot_s = Q;
    if (dir == ROT_LEFT) begin
      rot_s = {Q[WIDTH-2:0], Q[WIDTH-1]};
    end else begin
      rot_s = {Q[0], Q[WIDTH-1:1]};
    end
  end

  // Register contents: reset, load, rotate or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= '0;
    end else if (load) begin
      Q <= data;
    end else if (shift_en) begin
      Q <= rot_s;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Request-driven controller: loads the rotating register, rotates it req_amt
// times in the latched direction, then pulses done for one cycle.
module rotate_sequencer
  import rotate_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [AMT_W-1:0] cnt_r;
  logic             dir_r;
  logic             accept_s;
  logic             shift_en_s;

  assign accept_s   = (state_r == ST_IDLE) && req_valid;
  assign shift_en_s = (state_r == ST_SHIFT);

  // Next-state selection; a zero amount skips SHIFT entirely
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s = (req_amt != {AMT_W{1'b0}}) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == AMT_W'(1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, remaining-rotation count and latched direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {AMT_W{1'b0}};
      dir_r   <= ROT_RIGHT;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        cnt_r <= req_amt;
        dir_r <= req_dir;
      end else if (shift_en_s) begin
        cnt_r <= cnt_r - AMT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);

  rotate_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .shift_en (shift_en_s),
    .dir      (dir_r),
    .data     (req_data),
    .Q        (Q)
  );

endmodule
